// File: rtl/next_address_sequencer.sv
// next_address_sequencer: microprogram next-address selection with a 4-deep return stack
module next_address_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Condition_Control,
  input  logic [2:0] N,
  input  logic [7:0] CR_Address,
  input  logic [7:0] Encoder_Address,
  output logic [7:0] State,
  output logic [2:0] Stack_Depth,
  output logic       Stack_Error
);
  logic [7:0] stack [4];
  logic [7:0] inc, top, nxt;
  logic full, empty, push, pop, err_set;
  always_comb begin
    inc = State + 8'd1;
    full = Stack_Depth == 3'd4;
    empty = Stack_Depth == 3'd0;
    top = stack[Stack_Depth[1:0] - 2'd1];
    push = N == 3'b101 && !full;
    pop = N == 3'b110 && !empty;
    err_set = (N == 3'b101 && full) || (N == 3'b110 && empty);
    nxt = inc;
    case (N)
      3'b000: nxt = Encoder_Address;
      3'b001: nxt = 8'd0;
      3'b010: nxt = CR_Address;
      3'b011: nxt = Condition_Control ? CR_Address : inc;
      3'b100: nxt = inc;
      3'b101: nxt = CR_Address;
      3'b110: nxt = empty ? 8'd0 : top;
      3'b111: nxt = Condition_Control ? inc : State;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      State <= 8'd0;
      Stack_Depth <= 3'd0;
      Stack_Error <= 1'b0;
    end else begin
      State <= nxt;
      Stack_Depth <= push ? Stack_Depth + 3'd1 : pop ? Stack_Depth - 3'd1 : Stack_Depth;
      Stack_Error <= Stack_Error | err_set;
    end
  end
  always_ff @(posedge Clk)
    if (push) stack[Stack_Depth[1:0]] <= inc;
endmodule

// File: tb/tb_next_address_sequencer.sv
// tb_next_address_sequencer: directed and random checks against a queue-based reference model
module tb_next_address_sequencer;
  logic Clk = 0, Reset, Condition_Control;
  logic [2:0] N;
  logic [7:0] CR_Address, Encoder_Address, State;
  logic [2:0] Stack_Depth;
  logic Stack_Error;
  int total = 0, bad = 0;
  int m_state = 0;
  bit m_err = 0;
  int q[$];
  next_address_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Condition_Control(Condition_Control), .N(N),
    .CR_Address(CR_Address), .Encoder_Address(Encoder_Address),
    .State(State), .Stack_Depth(Stack_Depth), .Stack_Error(Stack_Error)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input bit rst, input int n, input bit cc, input int cr, input int enc);
    int inc, ns;
    Reset = rst; N = 3'(n); Condition_Control = cc; CR_Address = 8'(cr); Encoder_Address = 8'(enc);
    inc = (m_state + 1) % 256;
    ns = m_state;
    if (rst) begin
      ns = 0; q.delete(); m_err = 0;
    end else
      case (n)
        0: ns = enc;
        1: ns = 0;
        2: ns = cr;
        3: ns = cc ? cr : inc;
        4: ns = inc;
        5: begin
          ns = cr;
          if (q.size() == 4) m_err = 1; else q.push_back(inc);
        end
        6: if (q.size() == 0) begin ns = 0; m_err = 1; end else ns = q.pop_back();
        default: ns = cc ? inc : m_state;
      endcase
    m_state = ns;
    @(posedge Clk); #1;
    chk("state", int'(State), m_state);
    chk("depth", int'(Stack_Depth), q.size());
    chk("error", int'(Stack_Error), int'(m_err));
  endtask
  initial begin
    #1;
    step(1, 4, 0, 0, 0);
    chk("rst_state", State, 0);
    repeat (3) step(0, 4, 0, 0, 0);
    chk("inc3", State, 3);
    step(0, 2, 0, 8'h10, 0);
    step(0, 3, 1, 8'h40, 0);
    chk("cj_taken", State, 8'h40);
    step(0, 2, 0, 8'h10, 0);
    step(0, 3, 0, 8'h40, 0);
    chk("cj_not", State, 8'h11);
    step(0, 2, 0, 8'h20, 0);
    repeat (3) step(0, 7, 0, 8'h99, 0);
    chk("wait_hold", State, 8'h20);
    step(0, 7, 1, 8'h99, 0);
    chk("wait_go", State, 8'h21);
    step(0, 2, 0, 8'h05, 0);
    step(0, 5, 0, 8'h30, 0);
    step(0, 4, 0, 0, 0);
    step(0, 5, 0, 8'h50, 0);
    chk("nest_call", State, 8'h50);
    chk("nest_depth", Stack_Depth, 2);
    step(0, 6, 0, 0, 0);
    chk("ret1", State, 8'h32);
    step(0, 6, 0, 0, 0);
    chk("ret2", State, 8'h06);
    step(0, 0, 0, 0, 8'hA7);
    chk("dispatch", State, 8'hA7);
    step(1, 4, 0, 0, 0);
    repeat (5) step(0, 5, 0, 8'h80, 0);
    chk("ovf_depth", Stack_Depth, 4);
    chk("ovf_err", Stack_Error, 1);
    repeat (3) step(0, 6, 0, 0, 0);
    chk("ovf_ret3", State, 8'h81);
    step(0, 6, 0, 0, 0);
    chk("ovf_ret4", State, 8'h01);
    step(0, 6, 0, 0, 0);
    chk("udf_state", State, 0);
    chk("udf_err", Stack_Error, 1);
    step(0, 1, 0, 0, 0);
    chk("err_sticky", Stack_Error, 1);
    step(0, 2, 0, 8'hFF, 0);
    step(0, 4, 0, 0, 0);
    chk("wrap", State, 0);
    step(0, 5, 0, 8'h44, 0);
    step(1, 2, 0, 8'h77, 0);
    chk("rst_over", State, 0);
    chk("rst_err", Stack_Error, 0);
    step(0, 6, 0, 0, 0);
    chk("rst_udf", Stack_Error, 1);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7), 1'($urandom),
           $urandom_range(0, 255), $urandom_range(0, 255));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
